aidc_lite_cmd_sched: RTL and testbench
======================================

Name: aidc_lite_cmd_sched

Overview:
Command scheduler in front of the AIDC-Lite compression engine's control interface. Software posts (src, dst, len) descriptors through an APB slave into a small queue. The block issues the descriptors to the engine one at a time: it presents the fields, pulses start, and waits for done. Completion, overflow and error status are reported back over APB, so software no longer polls the engine per command.

Parameters:
QDEPTH, 4, descriptor queue depth (power of two, >=2)
ADDR_W, 32, width of src/dst addresses and APB data
LEN_W, 32, width of length field
TIMEOUT_CYC, 100000, watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous active-low reset
psel  in  1  APB select
penable  in  1  APB enable
pwrite  in  1  APB write
paddr  in  12  APB byte address
pwdata  in  32  APB write data
prdata  out  32  APB read data
pready  out  1  APB ready, tied 1 (zero wait states)
pslverr  out  1  APB error, valid in the access phase
eng_src_addr  out  ADDR_W  source address to engine
eng_dst_addr  out  ADDR_W  destination address to engine
eng_len  out  LEN_W  byte length to engine
eng_start  out  1  one-cycle start pulse
eng_done  in  1  one-cycle completion pulse from engine
irq  out  1  level interrupt, = done_cnt!=0 & CTRL.ie

Behaviour:
- Reset: all eng_* = 0, prdata = 0, pslverr = 0, irq = 0. Queue empty, FSM IDLE, all registers 0.
- APB access = psel&penable. pready is always 1. Reads are combinational in the access phase. Unmapped addresses read 0 with pslverr=0.
- Register map:
  - 0x00 SRC (RW staging)
  - 0x04 DST (RW staging)
  - 0x08 LEN (RW staging)
  - 0x0C PUSH (WO; any write enqueues SRC/DST/LEN)
  - 0x10 STATUS (RO): bit0 busy (FSM!=IDLE), bit1 empty, bit2 full, bit3 ovf sticky, bit4 err sticky, bit5 tmo sticky, bits[15:8] queue count
  - 0x14 DONE_CNT (RO count of completed commands; any write clears it to 0)
  - 0x18 CTRL: bit0 en, bit1 flush (self-clearing, reads 0), bit2 ie, bit3 write-1 clears all sticky bits
- PUSH with queue full: descriptor dropped, ovf set, pslverr=1 for that access.
- PUSH with LEN=0: descriptor dropped, err set, pslverr=1.
- Any other access: pslverr=0.
- Queue: circular, pointers wrap modulo QDEPTH. Count has $clog2(QDEPTH)+1 bits. A push and a pop on the same edge leave the count unchanged and are both legal at full or empty.
- FSM states IDLE, ISSUE, WAIT:
  - IDLE -> ISSUE when en=1 and queue not empty. On that edge, eng_src_addr/eng_dst_addr/eng_len load from the queue head, the head pops, and eng_start goes to 1.
  - ISSUE -> WAIT unconditionally. eng_start returns to 0, so it is high for exactly one cycle.
  - WAIT -> IDLE on the edge where eng_done=1. DONE_CNT increments on the same edge and saturates at 2^32-1.
- eng_* hold their value until the next issue.
- Latency: a PUSH sampled at edge E0 into an idle, enabled block gives eng_start high from E1 to E2.
- Back-to-back: eng_done at edge Ed gives the next eng_start from Ed+1 (one IDLE cycle between commands).
- eng_done in IDLE or ISSUE: ignored for counting, err set.
- eng_done coincident with a DONE_CNT clear write: the clear wins, result 0.
- Clearing en during ISSUE or WAIT: the in-flight command completes normally; no new issue until en=1 again.
- flush: empties the queue on the same edge. It does not abort the in-flight command. A push in the same access cycle as flush is impossible (single APB port).
- Asynchronous reset mid-command: everything returns to reset values immediately and in-flight state is lost. The engine is expected to be reset by the same rst_n.

Optional Feature:
AIDC_SCHED_TIMEOUT_EN
- Defined: a watchdog counter clears on entry to WAIT and increments each cycle in WAIT. If it reaches TIMEOUT_CYC with no eng_done, the FSM returns to IDLE, tmo is set, and DONE_CNT is not incremented. An eng_done arriving later is treated as spurious and sets err.
- Not defined: no counter; WAIT waits indefinitely and STATUS bit5 reads 0.

Test Plan:
- Reset, program SRC=0x0001_0000, DST=0x0002_0000, LEN=0x1000, PUSH, en=1 -> eng_start high exactly one cycle with those values; after the model returns eng_done, DONE_CNT=1, STATUS busy=0, empty=1.
- With en=0, push 4 descriptors, then push a 5th -> 5th access pslverr=1, STATUS count=4, full=1, ovf=1. Set en=1 -> 4 starts in FIFO order, each separated from the previous done by 1 cycle; DONE_CNT=4.
- PUSH with LEN=0 -> pslverr=1, err=1, count stays 0, no eng_start.
- Queue 3 descriptors and let the first issue; write flush during WAIT -> count=0, first command's done still gives DONE_CNT=1, no further starts.
- Pulse eng_done while IDLE -> err=1, DONE_CNT unchanged. CTRL bit3 write -> ovf/err/tmo all 0.
- With AIDC_SCHED_TIMEOUT_EN and TIMEOUT_CYC=50, engine never responds -> FSM back to IDLE 50 cycles after entering WAIT, tmo=1, DONE_CNT=0, next queued descriptor issues.

Source files
------------

// File: rtl/aidc_lite_cmd_sched.sv
// aidc_lite_cmd_sched: APB-programmed descriptor queue that issues (src, dst, len)
// commands to the AIDC-Lite engine one at a time and collects completion status.
// Optional watchdog on the engine handshake: define AIDC_SCHED_TIMEOUT_EN.
module aidc_lite_cmd_sched #(
   parameter int QDEPTH      = 4,
   parameter int ADDR_W      = 32,
   parameter int LEN_W       = 32,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [11:0]       paddr,
   input  logic [31:0]       pwdata,
   output logic [31:0]       prdata,
   output logic              pready,
   output logic              pslverr,
   output logic [ADDR_W-1:0] eng_src_addr,
   output logic [ADDR_W-1:0] eng_dst_addr,
   output logic [LEN_W-1:0]  eng_len,
   output logic              eng_start,
   input  logic              eng_done,
   output logic              irq
);

   localparam int PTR_W = $clog2(QDEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;

   localparam logic [11:0] A_SRC    = 12'h000;
   localparam logic [11:0] A_DST    = 12'h004;
   localparam logic [11:0] A_LEN    = 12'h008;
   localparam logic [11:0] A_PUSH   = 12'h00C;
   localparam logic [11:0] A_STATUS = 12'h010;
   localparam logic [11:0] A_DONE   = 12'h014;
   localparam logic [11:0] A_CTRL   = 12'h018;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] srcStage_q, dstStage_q;
   logic [LEN_W-1:0]  lenStage_q;
   logic [ADDR_W-1:0] qSrc_q [QDEPTH];
   logic [ADDR_W-1:0] qDst_q [QDEPTH];
   logic [LEN_W-1:0]  qLen_q [QDEPTH];
   logic [PTR_W-1:0]  head_q, tail_q;
   logic [CNT_W-1:0]  count_q;
   logic              en_q, ie_q, ovf_q, err_q, tmo_q;
   logic [31:0]       doneCnt_q;

   logic apbWr, apbRd, empty, full, pop, pushReq, lenZero, push, pushOvf, pushErr;
   logic flush, clrSticky, doneOk, spurious, doneClr, timeoutHit;

   assign apbWr     = psel & penable & pwrite;
   assign apbRd     = psel & penable & ~pwrite;
   assign empty     = (count_q == '0);
   assign full      = (count_q == CNT_W'(QDEPTH));
   // A pop on the same edge frees a slot, so a push at full is still accepted then.
   assign pop       = (state_q == IDLE) & en_q & ~empty;
   assign pushReq   = apbWr & (paddr == A_PUSH);
   assign lenZero   = (lenStage_q == '0);
   assign pushErr   = pushReq & lenZero;
   assign pushOvf   = pushReq & ~lenZero & full & ~pop;
   assign push      = pushReq & ~lenZero & (~full | pop);
   assign flush     = apbWr & (paddr == A_CTRL) & pwdata[1];
   assign clrSticky = apbWr & (paddr == A_CTRL) & pwdata[3];
   assign doneClr   = apbWr & (paddr == A_DONE);
   assign doneOk    = (state_q == WAIT) & eng_done;
   assign spurious  = (state_q != WAIT) & eng_done;

   assign pready  = 1'b1;
   assign pslverr = pushOvf | pushErr;
   assign irq     = (doneCnt_q != '0) & ie_q;

`ifdef AIDC_SCHED_TIMEOUT_EN
   logic [31:0] wdog_q;

   assign timeoutHit = (state_q == WAIT) & ~eng_done & (wdog_q == 32'(TIMEOUT_CYC - 1));

   // Watchdog: zeroed while issuing so it starts at 0 on entry to WAIT, then counts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         wdog_q <= '0;
      else if (state_q == ISSUE)
         wdog_q <= '0;
      else if (state_q == WAIT)
         wdog_q <= wdog_q + 32'd1;
   end
`else
   assign timeoutHit = 1'b0;
`endif

   // Next-state logic for the issue/wait handshake with the engine.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (pop) state_d = ISSUE;
         ISSUE:   state_d = WAIT;
         WAIT:    if (eng_done || timeoutHit) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Circular descriptor queue; flush wins over the pop that may share its edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < QDEPTH; i++) begin
            qSrc_q[i] <= '0;
            qDst_q[i] <= '0;
            qLen_q[i] <= '0;
         end
      end else if (flush) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            qSrc_q[tail_q] <= srcStage_q;
            qDst_q[tail_q] <= dstStage_q;
            qLen_q[tail_q] <= lenStage_q;
            tail_q         <= tail_q + 1'b1;
         end
         if (pop) head_q <= head_q + 1'b1;
         if (push && !pop)      count_q <= count_q + 1'b1;
         else if (pop && !push) count_q <= count_q - 1'b1;
      end
   end

   // Engine-facing outputs load from the queue head on issue and hold until the next one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eng_src_addr <= '0;
         eng_dst_addr <= '0;
         eng_len      <= '0;
         eng_start    <= 1'b0;
      end else begin
         eng_start <= pop;
         if (pop) begin
            eng_src_addr <= qSrc_q[head_q];
            eng_dst_addr <= qDst_q[head_q];
            eng_len      <= qLen_q[head_q];
         end
      end
   end

   // Software-visible registers: staging, control, sticky flags and completion count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         srcStage_q <= '0;
         dstStage_q <= '0;
         lenStage_q <= '0;
         en_q       <= 1'b0;
         ie_q       <= 1'b0;
         ovf_q      <= 1'b0;
         err_q      <= 1'b0;
         tmo_q      <= 1'b0;
         doneCnt_q  <= '0;
      end else begin
         if (apbWr && paddr == A_SRC) srcStage_q <= ADDR_W'(pwdata);
         if (apbWr && paddr == A_DST) dstStage_q <= ADDR_W'(pwdata);
         if (apbWr && paddr == A_LEN) lenStage_q <= LEN_W'(pwdata);
         if (apbWr && paddr == A_CTRL) begin
            en_q <= pwdata[0];
            ie_q <= pwdata[2];
         end
         ovf_q <= (ovf_q & ~clrSticky) | pushOvf;
         err_q <= (err_q & ~clrSticky) | pushErr | spurious;
         tmo_q <= (tmo_q & ~clrSticky) | timeoutHit;
         if (doneClr)
            doneCnt_q <= '0;
         else if (doneOk && doneCnt_q != '1)
            doneCnt_q <= doneCnt_q + 32'd1;
      end
   end

   // Zero-wait-state read mux, driven only during a read access phase.
   always_comb begin
      prdata = '0;
      if (apbRd) begin
         case (paddr)
            A_SRC:    prdata = 32'(srcStage_q);
            A_DST:    prdata = 32'(dstStage_q);
            A_LEN:    prdata = 32'(lenStage_q);
            A_STATUS: prdata = {16'd0, 8'(count_q), 2'b00, tmo_q, err_q, ovf_q,
                                full, empty, (state_q != IDLE)};
            A_DONE:   prdata = doneCnt_q;
            A_CTRL:   prdata = {29'd0, ie_q, 1'b0, en_q};
            default:  prdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_aidc_lite_cmd_sched.sv
// tb_aidc_lite_cmd_sched: directed bench for the command scheduler with a small
// engine responder that answers each start with a done pulse after a set delay.
module tb_aidc_lite_cmd_sched;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [11:0] paddr = '0;
   logic [31:0] pwdata = '0;
   logic [31:0] prdata;
   logic        pready, pslverr;
   logic [31:0] eng_src_addr, eng_dst_addr, eng_len;
   logic        eng_start;
   logic        eng_done = 1'b0;
   logic        irq;

   int errCnt = 0;
   int chkCnt = 0;
   int cyc = 0;
   int doneDelay = 3;
   int lastWrCyc = 0;
   int longStarts = 0;
   logic prevStart = 1'b0;

   logic [31:0] startSrcQ[$], startDstQ[$], startLenQ[$];
   int startCycQ[$], doneEdgeQ[$];

   logic [31:0] rd;
   logic        se;
   int          nStarts;

   aidc_lite_cmd_sched dut (
      .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
      .pslverr(pslverr), .eng_src_addr(eng_src_addr), .eng_dst_addr(eng_dst_addr),
      .eng_len(eng_len), .eng_start(eng_start), .eng_done(eng_done), .irq(irq)
   );

   always #5 clk = ~clk;

   // Edge counter used to time starts against pushes and dones.
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Records every start pulse and flags any that last longer than one cycle.
   initial forever begin
      @(negedge clk);
      if (eng_start) begin
         startSrcQ.push_back(eng_src_addr);
         startDstQ.push_back(eng_dst_addr);
         startLenQ.push_back(eng_len);
         startCycQ.push_back(cyc);
         if (prevStart) longStarts++;
      end
      prevStart = eng_start;
   end

   // Engine model: done pulse doneDelay cycles after each observed start.
   initial forever begin
      @(negedge clk);
      if (eng_start) begin
         repeat (doneDelay) @(negedge clk);
         eng_done = 1'b1;
         doneEdgeQ.push_back(cyc + 1);
         @(negedge clk);
         eng_done = 1'b0;
      end
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chkCnt++;
      if (got !== exp) begin
         errCnt++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic apbWrite(input logic [11:0] a, input logic [31:0] d, output logic err);
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
      @(posedge clk); #1;
      penable = 1'b1;
      #3 err = pslverr;
      @(posedge clk);
      #1;
      lastWrCyc = cyc;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic apbRead(input logic [11:0] a, output logic [31:0] d);
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
      @(posedge clk); #1;
      penable = 1'b1;
      #3 d = prdata;
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
   endtask

   task automatic applyStimulus(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l,
                                output logic err);
      logic e;
      apbWrite(12'h000, s, e);
      apbWrite(12'h004, d, e);
      apbWrite(12'h008, l, e);
      apbWrite(12'h00C, 32'd0, err);
   endtask

   initial begin
      // Reset values
      #12;
      checkOutput("rst_start", {31'd0, eng_start}, 32'd0);
      checkOutput("rst_src", eng_src_addr, 32'd0);
      checkOutput("rst_prdata", prdata, 32'd0);
      checkOutput("rst_pslverr", {31'd0, pslverr}, 32'd0);
      checkOutput("rst_irq", {31'd0, irq}, 32'd0);
      checkOutput("rst_pready", {31'd0, pready}, 32'd1);
      @(negedge clk); rst_n = 1'b1;
      apbRead(12'h010, rd); checkOutput("rst_status", rd, 32'h2);
      apbRead(12'h040, rd); checkOutput("unmapped_rd", rd, 32'h0);

      // Single command: latency, one-cycle start, completion
      apbWrite(12'h018, 32'h1, se);
      applyStimulus(32'h0001_0000, 32'h0002_0000, 32'h1000, se);
      checkOutput("t1_pslverr", {31'd0, se}, 32'd0);
      repeat (20) @(posedge clk);
      checkOutput("t1_nstart", startCycQ.size(), 1);
      if (startCycQ.size() >= 1) begin
         checkOutput("t1_latency", startCycQ[0], lastWrCyc + 1);
         checkOutput("t1_src", startSrcQ[0], 32'h0001_0000);
         checkOutput("t1_dst", startDstQ[0], 32'h0002_0000);
         checkOutput("t1_len", startLenQ[0], 32'h1000);
      end
      checkOutput("t1_longstart", longStarts, 0);
      apbRead(12'h014, rd); checkOutput("t1_donecnt", rd, 32'd1);
      apbRead(12'h010, rd); checkOutput("t1_status", rd, 32'h2);
      apbRead(12'h000, rd); checkOutput("t1_src_rb", rd, 32'h0001_0000);

      // Fill the queue with en=0, overflow, then drain in order
      apbWrite(12'h018, 32'h0, se);
      apbWrite(12'h014, 32'h0, se);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(32'h100 + i, 32'h200 + i, 32'h10 + i, se);
         checkOutput("t2_push_ok", {31'd0, se}, 32'd0);
      end
      applyStimulus(32'h999, 32'h999, 32'h99, se);
      checkOutput("t2_push_ovf", {31'd0, se}, 32'd1);
      apbRead(12'h010, rd); checkOutput("t2_status_full", rd, 32'h40C);
      startSrcQ.delete(); startDstQ.delete(); startLenQ.delete();
      startCycQ.delete(); doneEdgeQ.delete();
      apbWrite(12'h018, 32'h1, se);
      repeat (60) @(posedge clk);
      checkOutput("t2_nstart", startCycQ.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < startCycQ.size()) begin
            checkOutput("t2_src", startSrcQ[i], 32'h100 + i);
            checkOutput("t2_dst", startDstQ[i], 32'h200 + i);
            checkOutput("t2_len", startLenQ[i], 32'h10 + i);
            if (i > 0 && i - 1 < doneEdgeQ.size())
               checkOutput("t2_gap", startCycQ[i], doneEdgeQ[i-1] + 1);
         end
      end
      apbRead(12'h014, rd); checkOutput("t2_donecnt", rd, 32'd4);
      checkOutput("t2_irq_off", {31'd0, irq}, 32'd0);
      apbWrite(12'h018, 32'h5, se);
      checkOutput("t2_irq_on", {31'd0, irq}, 32'd1);

      // Zero length push is rejected
      apbWrite(12'h018, 32'h9, se);
      nStarts = startCycQ.size();
      applyStimulus(32'h5, 32'h6, 32'h0, se);
      checkOutput("t3_pslverr", {31'd0, se}, 32'd1);
      repeat (10) @(posedge clk);
      apbRead(12'h010, rd); checkOutput("t3_status", rd, 32'h12);
      checkOutput("t3_nostart", startCycQ.size(), nStarts);

      // Flush during WAIT keeps the in-flight command
      apbWrite(12'h014, 32'h0, se);
      doneDelay = 30;
      nStarts = startCycQ.size();
      applyStimulus(32'hA0, 32'hB0, 32'h40, se);
      apbWrite(12'h00C, 32'h0, se);
      apbWrite(12'h00C, 32'h0, se);
      apbWrite(12'h018, 32'hB, se);
      apbRead(12'h010, rd); checkOutput("t4_status_flush", rd, 32'h3);
      apbRead(12'h018, rd); checkOutput("t4_ctrl_rb", rd, 32'h1);
      repeat (60) @(posedge clk);
      checkOutput("t4_nstart", startCycQ.size(), nStarts + 1);
      apbRead(12'h014, rd); checkOutput("t4_donecnt", rd, 32'd1);
      apbRead(12'h010, rd); checkOutput("t4_status_end", rd, 32'h2);

      // Spurious done while idle, then sticky clear
      @(negedge clk); eng_done = 1'b1;
      @(negedge clk); eng_done = 1'b0;
      apbRead(12'h010, rd); checkOutput("t5_status_err", rd, 32'h12);
      apbRead(12'h014, rd); checkOutput("t5_donecnt", rd, 32'd1);
      apbWrite(12'h018, 32'h9, se);
      apbRead(12'h010, rd); checkOutput("t5_status_clr", rd, 32'h2);

      // Asynchronous reset in the middle of a command
      applyStimulus(32'hC0, 32'hD0, 32'h80, se);
      repeat (3) @(posedge clk);
      apbRead(12'h010, rd); checkOutput("t6_busy", rd, 32'h3);
      @(negedge clk); rst_n = 1'b0;
      #1;
      checkOutput("t6_rst_src", eng_src_addr, 32'd0);
      checkOutput("t6_rst_len", eng_len, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      apbRead(12'h010, rd); checkOutput("t6_status", rd, 32'h2);
      apbRead(12'h014, rd); checkOutput("t6_donecnt", rd, 32'd0);
      apbRead(12'h008, rd); checkOutput("t6_len_reg", rd, 32'd0);

      $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
      $finish;
   end

endmodule
